// File: rtl/dbus_sram_responder_pkg.sv
// Shared types for the data-bus SRAM responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dbus_sram_responder_pkg;

  // Width of the wait-state counter; supports LATENCY 0..15.
  localparam int DBUS_LAT_W = 4;

  // Access size, log2 of the byte count (1/2/4/8 bytes).
  typedef enum logic [2:0] {
    MSIZE_1 = 3'd0,
    MSIZE_2 = 3'd1,
    MSIZE_4 = 3'd2,
    MSIZE_8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
    logic        err;
  } dbus_resp_t;

  // Responder FSM: accept, count wait states, respond.
  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } dbus_rsp_state_t;

  // What the responder keeps of a request once it has been sampled.
  typedef struct packed {
    logic        in_range;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } dbus_acc_t;

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response signal bundle between memory stage and responder.
// Latency: n/a (wires only).
// Backpressure: none; requester holds the request until resp_data_ok.
interface dbus_sram_responder_if;
  import dbus_sram_responder_pkg::*;

  logic        req_valid;
  logic [63:0] req_addr;
  msize_t      req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;

  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data, resp_err
  );
endinterface

// File: rtl/dbus_sram_responder_sram_1rw_be.sv
// Single-port synchronous SRAM with byte enables and a registered read port.
// Latency: 1 cycle; read data reflects the write merged on the same edge.
// Backpressure: none; one access per enabled cycle.
module sram_1rw_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WIDTH       = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [WIDTH/8-1:0]             i_be,
  input  logic [WIDTH-1:0]               i_wdat,
  output logic [WIDTH-1:0]               o_rdat
);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_merged;

  // Overlay enabled byte lanes of the write data onto the stored word.
  always_comb begin
    w_merged = r_mem[i_addr];
    for (int b = 0; b < NB; b++) begin
      if (i_be[b]) w_merged[8*b +: 8] = i_wdat[8*b +: 8];
    end
  end

  // Array update; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (i_en) r_mem[i_addr] <= w_merged;
  end

  // Output register captures the post-merge word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_en) r_q <= w_merged;
  end

  assign o_rdat = r_q;
endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder terminating load/store requests on a single-port SRAM.
// Latency: response LATENCY+1 cycles after capture; one access per LATENCY+2 cycles.
// Backpressure: single outstanding request; requests seen during WAIT/RESP are ignored.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  dbus_sram_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [DBUS_LAT_W-1:0] LAT_M1 =
    (LATENCY > 0) ? DBUS_LAT_W'(LATENCY - 1) : '0;

  dbus_rsp_state_t       r_state, w_nxt;
  logic [DBUS_LAT_W-1:0] r_cnt;
  dbus_acc_t             r_acc, w_live_acc, w_acc;
  logic [IDX_W-1:0]      r_idx, w_live_idx, w_idx;
  logic [63:0]           w_off;
  logic [63:0]           w_rdat;
  logic                  r_err;
  logic                  w_commit;
  logic                  w_unused;

  // Decode the live request: word offset from the base and range check.
  assign w_off                = bus.req_addr - BASE_ADDR;
  assign w_live_idx           = w_off[IDX_W+2:3];
  assign w_live_acc.in_range  = (bus.req_addr >= BASE_ADDR) &&
                                (w_off[63:3] < 61'(DEPTH_WORDS));
  assign w_live_acc.strobe    = bus.req_strobe;
  assign w_live_acc.wdata     = bus.req_data;
  // Size is informational (lanes come from the strobe); byte offset is ignored.
  assign w_unused             = ^{bus.req_size, w_off[2:0]};

  // With zero wait states the commit coincides with capture, so use the live request.
  assign w_acc    = (r_state == RSP_IDLE) ? w_live_acc : r_acc;
  assign w_idx    = (r_state == RSP_IDLE) ? w_live_idx : r_idx;
  assign w_commit = reset && (w_nxt == RSP_RESP);

  // State register and wait-state counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RSP_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == RSP_IDLE && w_nxt == RSP_WAIT) r_cnt <= LAT_M1;
      else if (r_state == RSP_WAIT && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end
  end

  // Next state: capture in IDLE, count down in WAIT, single-cycle RESP.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      RSP_IDLE: if (bus.req_valid) w_nxt = (LATENCY == 0) ? RSP_RESP : RSP_WAIT;
      RSP_WAIT: if (r_cnt == '0)   w_nxt = RSP_RESP;
      RSP_RESP: w_nxt = RSP_IDLE;
      default:  w_nxt = RSP_IDLE;
    endcase
  end

  // Hold the sampled request so later bus changes cannot disturb the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (r_state == RSP_IDLE && bus.req_valid) begin
      r_acc <= w_live_acc;
      r_idx <= w_live_idx;
    end
  end

  // Error flag is registered alongside the read data on the commit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_err <= 1'b0;
    else if (w_commit) r_err <= ~w_acc.in_range;
  end

  sram_1rw_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .WIDTH      (64)
  ) u_sram (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_commit),
    .i_addr(w_idx),
    .i_be  (w_acc.strobe & {8{w_acc.in_range}}),
    .i_wdat(w_acc.wdata),
    .o_rdat(w_rdat)
  );

  // Outputs decode registered state only; out-of-range reads return zero.
  always_comb begin
    bus.resp_addr_ok = (r_state == RSP_RESP);
    bus.resp_data_ok = (r_state == RSP_RESP);
    bus.resp_data    = r_err ? 64'd0 : w_rdat;
    bus.resp_err     = r_err;
  end
endmodule
